a_loader: RTL and testbench

A_LOADER -- requirements
Module: a_loader

---
 rtl/a_loader_pkg.sv | 26 ++
 rtl/a_row_packer.sv | 59 +++++
 rtl/a_loader.sv | 152 +++++++++++++++
 tb/tb_a_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/a_loader_pkg.sv
// Shared definitions for the A-matrix loader: FSM state encoding, default
// geometry, and helpers for beat/stream lengths.
package a_loader_pkg;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DONE
  } state_e;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_DIM     = 8;
  localparam int unsigned DEF_LANES   = 2;

  // Number of enabled shift cycles needed to push a DIM x DIM matrix through
  // the systolic array.
  function automatic int unsigned stream_len(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

  // Number of input beats that make up one row.
  function automatic int unsigned beats_per_row(input int unsigned dim, input int unsigned lanes);
    return dim / lanes;
  endfunction

endpackage

// File: rtl/a_row_packer.sv
// Assembles LANES-wide input beats into a full DIM-element row. The finished
// row is latched into the output register on the last beat so it stays stable
// while the next row is being gathered.
module a_row_packer
  import a_loader_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned DIM     = DEF_DIM,
  parameter int unsigned LANES   = DEF_LANES
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     take_i,
  input  logic [LANES*BITS_AB-1:0] data_i,
  output logic                     last_o,
  output logic [DIM*BITS_AB-1:0]   row_o
);

  localparam int unsigned BEATS = beats_per_row(DIM, LANES);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BEATW = LANES * BITS_AB;

  logic [BW-1:0]          beat_q, beat_d;
  logic [DIM*BITS_AB-1:0] asm_q, asm_d;
  logic [DIM*BITS_AB-1:0] row_q, row_d;

  // Merge the incoming beat into its slot and advance the beat counter.
  always_comb begin
    asm_d  = asm_q;
    beat_d = beat_q;
    row_d  = row_q;
    last_o = (beat_q == BW'(BEATS - 1));
    if (take_i) begin
      asm_d[int'(beat_q)*BEATW +: BEATW] = data_i;
      if (last_o) begin
        beat_d = '0;
        row_d  = asm_d;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Assembly, beat counter and output row registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      asm_q  <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      asm_q  <= asm_d;
      row_q  <= row_d;
    end
  end

  assign row_o = row_q;

endmodule

// File: rtl/a_loader.sv
// A-matrix loader: collects DIM rows of DIM signed elements from a LANES-wide
// valid/ready beat stream, writes each row to memA, then drives 3*DIM-2
// enabled shift cycles (held off by stall) and pulses done.
// Optional feature macro: A_LOADER_STALL_CNT_EN adds a 16-bit stall_cnt output.
module a_loader
  import a_loader_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned DIM     = DEF_DIM,
  parameter int unsigned LANES   = DEF_LANES,
  localparam int unsigned RW     = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*BITS_AB-1:0] in_data,
  input  logic                     stall,
  output logic [DIM*BITS_AB-1:0]   Ain,
  output logic [RW-1:0]            Arow,
  output logic                     WrEn,
  output logic                     en,
  output logic                     busy,
  output logic                     done
`ifdef A_LOADER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned SLEN = stream_len(DIM);
  localparam int unsigned CW   = $clog2(SLEN + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(DIM - 1);

  if (DIM % LANES != 0) begin : g_bad_cfg
    $error("a_loader: DIM must be a multiple of LANES");
  end

  state_e        state_q;
  logic [RW-1:0] row_q;
  logic [RW-1:0] arow_q;
  logic          wren_q;
  logic          in_ready_q;
  logic          done_q;
  logic          taken_q;
  logic [CW-1:0] scnt_q;

  logic take;
  logic last_beat;
  logic enter_stream;

  // Handshake and FSM-derived combinational outputs.
  always_comb begin
    take         = in_valid && in_ready_q;
    enter_stream = (state_q == LOAD) && wren_q && (arow_q == LAST_ROW);
    en           = (state_q == STREAM) && !stall;
    busy         = (state_q != LOAD) || taken_q;
  end

  a_row_packer #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .LANES   (LANES)
  ) u_packer (
    .clk_i  (clk),
    .rst_i  (rst),
    .take_i (take),
    .data_i (in_data),
    .last_o (last_beat),
    .row_o  (Ain)
  );

  // Load/stream/done sequencing; in_ready drops the moment the final row's
  // last beat lands so the row-write cycle never overlaps a new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      row_q      <= '0;
      arow_q     <= '0;
      wren_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      taken_q    <= 1'b0;
      scnt_q     <= '0;
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (enter_stream) begin
            state_q    <= STREAM;
            scnt_q     <= '0;
            in_ready_q <= 1'b0;
          end else if (take && last_beat && (row_q == LAST_ROW)) begin
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
          if (take) begin
            taken_q <= 1'b1;
          end
          if (take && last_beat) begin
            wren_q <= 1'b1;
            arow_q <= row_q;
            row_q  <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
          end
        end
        STREAM: begin
          in_ready_q <= 1'b0;
          if (en) begin
            scnt_q <= scnt_q + 1'b1;
            if (scnt_q == CW'(SLEN - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q    <= LOAD;
          in_ready_q <= 1'b1;
          taken_q    <= 1'b0;
          row_q      <= '0;
          scnt_q     <= '0;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign Arow     = arow_q;
  assign WrEn     = wren_q;
  assign done     = done_q;

`ifdef A_LOADER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled STREAM cycles, restarted on each STREAM entry.
  always_ff @(posedge clk) begin
    if (rst || enter_stream) begin
      stall_cnt_q <= '0;
    end else if ((state_q == STREAM) && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_a_loader.sv
// Directed bench for a_loader (DIM=8, LANES=2, BITS_AB=8): a table of
// full-load scenarios plus hand-written reset sequences.
module tb_a_loader;

  localparam int unsigned BITS_AB = 8;
  localparam int unsigned DIM     = 8;
  localparam int unsigned LANES   = 2;
  localparam int unsigned RW      = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [LANES*BITS_AB-1:0] in_data = '0;
  logic                     stall = 1'b0;
  logic [DIM*BITS_AB-1:0]   Ain;
  logic [RW-1:0]            Arow;
  logic                     WrEn;
  logic                     en;
  logic                     busy;
  logic                     done;
`ifdef A_LOADER_STALL_CNT_EN
  logic [15:0]              stall_cnt;
`endif

  a_loader #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .LANES   (LANES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .stall    (stall),
    .Ain      (Ain),
    .Arow     (Arow),
    .WrEn     (WrEn),
    .en       (en),
    .busy     (busy),
    .done     (done)
`ifdef A_LOADER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Row r holds values 8r+1 .. 8r+8, element i in bits [8i +: 8].
  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(8 * r + i + 1);
    return v;
  endfunction

  typedef struct {
    int gap;        // 0: valid every cycle, 1: valid every other cycle
    int st_start;   // first STREAM cycle (0-based) with stall high
    int st_len;     // number of stalled cycles
    int exp_space;  // cycles between consecutive WrEn
    int exp_en;     // en cycles in the stream window
    int exp_done;   // STREAM cycle index carrying done
    int exp_scnt;   // stall_cnt after done
  } scen_t;

  scen_t scen[4];

  // One full load of beats 1..64 followed by its stream window; data 0xFFFF
  // with in_valid high is pushed whenever the bench has no beats left.
  task automatic run_load(input scen_t s);
    int nb = 0, cyc = 0, rows = 0, last_w = -1, sc = -1;
    int en_cnt = 0, done_off = -1;
    bit fin = 0, first_ok = 0, sp_ok = 1, row_ok = 1, rdy_ok = 1, en_ok = 1, busy_ok = 1;
    while (!fin && cyc < 400) begin
      @(posedge clk); #1;
      if (nb < 32) begin
        in_valid = (s.gap == 0) || (cyc % 2 == 0);
        in_data  = {8'(2 * nb + 2), 8'(2 * nb + 1)};
      end else begin
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
      end
      stall = (sc >= s.st_start) && (sc < s.st_start + s.st_len);
      @(negedge clk);
      if (cyc == 0) first_ok = in_ready && !done && !busy;
      if (nb > 0 && !busy) busy_ok = 0;
      if (nb >= 32 && in_ready) rdy_ok = 0;
      if (in_valid && in_ready && nb < 32) nb++;
      if (WrEn) begin
        if (Arow != RW'(rows) || Ain != exp_row(rows)) row_ok = 0;
        if (last_w >= 0 && cyc - last_w != s.exp_space) sp_ok = 0;
        last_w = cyc;
        rows++;
      end
      if (sc >= 0) begin
        if (done) begin
          if (en) en_ok = 0;
          done_off = sc;
          fin = 1;
        end else if (en != !stall) begin
          en_ok = 0;
        end
        if (en) en_cnt++;
        sc++;
      end else if (en || done) begin
        en_ok = 0;
      end
      if (WrEn && rows == 8) sc = 0;
      cyc++;
    end
    stall = 1'b0;
    chk("timeout", 64'(fin), 64'd1);
    chk("first_cycle", 64'(first_ok), 64'd1);
    chk("wren_rows", 64'(rows), 64'd8);
    chk("row_data", 64'(row_ok), 64'd1);
    chk("wren_spacing", 64'(sp_ok), 64'd1);
    chk("ready_low", 64'(rdy_ok), 64'd1);
    chk("busy", 64'(busy_ok), 64'd1);
    chk("en_count", 64'(en_cnt), 64'(s.exp_en));
    chk("en_vs_stall", 64'(en_ok), 64'd1);
    chk("done_offset", 64'(done_off), 64'(s.exp_done));
`ifdef A_LOADER_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(s.exp_scnt));
`endif
  endtask

  initial begin
    int wcnt;
    int bad;
    scen[0] = '{gap: 0, st_start: 0, st_len: 0, exp_space: 4, exp_en: 22, exp_done: 22, exp_scnt: 0};
    scen[1] = '{gap: 1, st_start: 0, st_len: 0, exp_space: 8, exp_en: 22, exp_done: 22, exp_scnt: 0};
    scen[2] = '{gap: 0, st_start: 5, st_len: 5, exp_space: 4, exp_en: 22, exp_done: 27, exp_scnt: 5};
    scen[3] = '{gap: 0, st_start: 0, st_len: 0, exp_space: 4, exp_en: 22, exp_done: 22, exp_scnt: 0};

    // Reset state, with in_valid high to show it is ignored.
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_Ain", Ain, 64'd0);
    chk("rst_Arow", 64'(Arow), 64'd0);
    chk("rst_ctrl", {59'd0, WrEn, en, done, busy, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rdy_rel0", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdy_rel1", 64'(in_ready), 64'd1);

    for (int i = 0; i < 4; i++) run_load(scen[i]);

    // Partial load of 13 beats, then reset: rows 0..2 only, nothing after.
    wcnt = 0;
    for (int b = 0; b < 13; b++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = {8'(2 * b + 2), 8'(2 * b + 1)};
      @(negedge clk);
      if (WrEn) wcnt++;
    end
    chk("partial_wren", 64'(wcnt), 64'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    bad = 0;
    @(negedge clk);
    if (WrEn || done) bad++;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_Ain", Ain, 64'd0);
    chk("midrst_ctrl", {59'd0, WrEn, en, done, busy, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rdy0", 64'(in_ready), 64'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (WrEn || done || busy || !in_ready) bad++;
    end
    chk("midrst_quiet", 64'(bad), 64'd0);
    run_load(scen[0]);

    in_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
